// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types and constants for the RPN sequencer.
//   - Calculator opcode constants (values 9..15 are not defined by the calculator).
//   - Sequencer FSM state enum.
//   - Program-word struct {op, data} as stored in program memory.
//   - clamp_len(): limits a requested instruction count to the memory depth.
package rpn_pkg;

  // Operand width of the calculator; the sequencer's W parameter must match it.
  localparam int unsigned DATA_W = 16;

  localparam logic [3:0] OP_POP  = 4'd0;
  localparam logic [3:0] OP_DUP  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_MOD  = 4'd6;
  localparam logic [3:0] OP_PUSH = 4'd7;
  localparam logic [3:0] OP_SWAP = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_CHECK,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [DATA_W-1:0] data;
  } prog_word_t;

  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/rpn_prog_mem.sv
// rpn_prog_mem: DEPTH-entry program store for the RPN sequencer.
// Ports:
//   clk      in   clock
//   i_we     in   write strobe (already gated by the owner while a run is active)
//   i_waddr  in   write address
//   i_wdata  in   program word to store
//   i_raddr  in   read address
//   o_rdata  out  program word at i_raddr (combinational read)
module rpn_prog_mem
  import rpn_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  prog_word_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output prog_word_t    o_rdata
);

  prog_word_t r_mem [DEPTH];

  // NOTE: the storage array has no reset branch; contents survive a reset and
  // only the control path is cleared, which keeps this a plain register file.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rpn_sequencer.sv
// rpn_sequencer: runs a stored RPN program against the stack calculator,
// one instruction every two cycles (ISSUE then CHECK), and stops at the first
// instruction the calculator flags as invalid.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   prog_we/addr/op/data       host program write port (ignored while busy)
//   prog_len                   instruction count, sampled on start, clamped to DEPTH
//   start                      run request (ignored while busy)
//   busy                       run in progress
//   done / error               run outcome, held until the next accepted start
//   err_pc                     index of the failing instruction
//   result / result_empty      calculator head / empty flag at completion
//   s_rst/s_op/s_in/s_apply    calculator drive
//   s_head/s_empty/s_valid     calculator status
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [3:0]    prog_op,
  input  logic [W-1:0]  prog_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] err_pc,
  output logic [W-1:0]  result,
  output logic          result_empty,
  output logic          s_rst,
  output logic [3:0]    s_op,
  output logic [W-1:0]  s_in,
  output logic          s_apply,
  input  logic [W-1:0]  s_head,
  input  logic          s_empty,
  input  logic          s_valid
);

  localparam int LEN_W = AW + 1;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [AW-1:0]    r_pc;
  logic             r_done;
  logic             r_error;
  logic [AW-1:0]    r_err_pc;
  logic [W-1:0]     r_result;
  logic             r_result_empty;
  logic [3:0]       r_s_op;
  logic [W-1:0]     r_s_in;
  logic             r_s_apply;

  logic             w_mem_we;
  logic [AW-1:0]    w_rd_addr;
  logic             w_last;
  prog_word_t       w_wdata;
  prog_word_t       w_word;

  assign w_mem_we = prog_we && (r_state == S_IDLE);
  assign w_wdata  = '{op: prog_op, data: prog_data};

  // The calculator drive is registered, so the word for the next ISSUE is
  // fetched one cycle early: pc in CLEAR, pc+1 in CHECK.
  assign w_rd_addr = (r_state == S_CHECK) ? r_pc + AW'(1) : r_pc;
  assign w_last    = ({1'b0, r_pc} == r_len - LEN_W'(1));

  rpn_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (prog_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_rd_addr),
    .o_rdata (w_word)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of the registers it tests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_len          <= '0;
      r_pc           <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_err_pc       <= '0;
      r_result       <= '0;
      r_result_empty <= 1'b1;
      r_s_op         <= '0;
      r_s_in         <= '0;
      r_s_apply      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= LEN_W'(clamp_len(32'(prog_len), 32'(DEPTH)));
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (r_len == '0) begin
            r_state <= S_FINISH;
          end else begin
            r_s_op    <= w_word.op;
            r_s_in    <= w_word.data;
            r_s_apply <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_s_apply <= 1'b0;
          r_state   <= S_CHECK;
        end
        S_CHECK: begin
          if (!s_valid) begin
            r_error  <= 1'b1;
            r_err_pc <= r_pc;
            r_state  <= S_IDLE;
          end else if (w_last) begin
            r_state <= S_FINISH;
          end else begin
            r_pc      <= r_pc + AW'(1);
            r_s_op    <= w_word.op;
            r_s_in    <= w_word.data;
            r_s_apply <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_FINISH: begin
          r_result       <= s_head;
          r_result_empty <= s_empty;
          r_done         <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy         = (r_state != S_IDLE);
  // The calculator is held in reset together with us, and cleared before a run.
  assign s_rst        = rst || (r_state == S_CLEAR);
  assign done         = r_done;
  assign error        = r_error;
  assign err_pc       = r_err_pc;
  assign result       = r_result;
  assign result_empty = r_result_empty;
  assign s_op         = r_s_op;
  assign s_in         = r_s_in;
  assign s_apply      = r_s_apply;

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: self-checking bench for rpn_sequencer. A behavioural stack
// calculator answers the sequencer's drive; program outcomes are predicted by
// running the program directly on a stack and counting two cycles per instruction.
module tb_rpn_sequencer;
  import rpn_pkg::*;

  localparam int W     = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  typedef struct packed {
    logic [31:0][15:0] d;
    logic [5:0]        sp;
  } stack_t;

  typedef struct packed {
    bit          err;
    int          pc;
    logic [15:0] res;
    bit          empty;
    int          lat;
  } exp_t;

  typedef struct packed {
    logic [0:3][3:0]  ops;
    logic [0:3][15:0] data;
    int               len;
    exp_t             e;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [3:0]    prog_op;
  logic [W-1:0]  prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          busy, done, error, result_empty;
  logic [AW-1:0] err_pc;
  logic [W-1:0]  result;
  logic          s_rst, s_apply;
  logic [3:0]    s_op;
  logic [W-1:0]  s_in;
  logic [W-1:0]  s_head  = '0;
  logic          s_empty = 1'b1;
  logic          s_valid = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0]  tm_op   [DEPTH];
  logic [15:0] tm_data [DEPTH];

  always #5 clk = ~clk;

  rpn_sequencer #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_op(prog_op), .prog_data(prog_data),
    .prog_len(prog_len), .start(start),
    .busy(busy), .done(done), .error(error), .err_pc(err_pc),
    .result(result), .result_empty(result_empty),
    .s_rst(s_rst), .s_op(s_op), .s_in(s_in), .s_apply(s_apply),
    .s_head(s_head), .s_empty(s_empty), .s_valid(s_valid)
  );

  // Calculator semantics: second-from-top op top; invalid ops leave the stack alone.
  function automatic bit calc_apply(inout stack_t st, input logic [3:0] op,
                                    input logic [15:0] din);
    int sp;
    logic [15:0] a, b, r;
    sp = int'(st.sp);
    b  = (sp > 0) ? st.d[sp-1] : '0;
    a  = (sp > 1) ? st.d[sp-2] : '0;
    r  = '0;
    case (op)
      OP_PUSH: begin
        if (sp >= 32) return 1'b0;
        st.d[sp] = din;
        st.sp    = st.sp + 6'd1;
      end
      OP_POP: begin
        if (sp < 1) return 1'b0;
        st.sp = st.sp - 6'd1;
      end
      OP_DUP: begin
        if (sp < 1 || sp >= 32) return 1'b0;
        st.d[sp] = b;
        st.sp    = st.sp + 6'd1;
      end
      OP_SWAP: begin
        if (sp < 2) return 1'b0;
        st.d[sp-1] = a;
        st.d[sp-2] = b;
      end
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD: begin
        if (sp < 2) return 1'b0;
        if ((op == OP_DIV || op == OP_MOD) && b == 16'd0) return 1'b0;
        case (op)
          OP_ADD:  r = a + b;
          OP_SUB:  r = a - b;
          OP_MUL:  r = a * b;
          OP_DIV:  r = a / b;
          default: r = a % b;
        endcase
        st.d[sp-2] = r;
        st.sp      = st.sp - 6'd1;
      end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  // Behavioural calculator attached to the DUT's s_* ports.
  stack_t m_st = '0;
  always @(posedge clk or posedge s_rst) begin
    bit v;
    if (s_rst) begin
      m_st = '0;
      s_valid <= 1'b1;
    end else if (s_apply) begin
      v = calc_apply(m_st, s_op, s_in);
      s_valid <= v;
    end
    s_head  <= (m_st.sp == 6'd0) ? 16'd0 : m_st.d[m_st.sp - 6'd1];
    s_empty <= (m_st.sp == 6'd0);
  end

  // Expected outcome of running the bench's copy of the program.
  function automatic exp_t ref_run(input int len_in);
    exp_t   e;
    stack_t st;
    int     len;
    st    = '0;
    len   = (len_in > DEPTH) ? DEPTH : len_in;
    e     = '0;
    e.lat = 2 * len + 2;
    for (int i = 0; i < len; i++) begin
      if (!calc_apply(st, tm_op[i], tm_data[i])) begin
        e.err = 1'b1;
        e.pc  = i;
        e.lat = 2 * i + 3;
        return e;
      end
    end
    e.empty = (st.sp == 6'd0);
    e.res   = e.empty ? 16'd0 : st.d[st.sp - 6'd1];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_word(input int a, input logic [3:0] op, input logic [15:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_op   = op;
    prog_data = d;
    @(posedge clk);
    #1 prog_we = 1'b0;
    tm_op[a]   = op;
    tm_data[a] = d;
  endtask

  // Starts a run and counts edges after the accepting edge until done/error.
  // poke_edge >= 1 pulses start (poke_we=0) or prog_we (poke_we=1) mid-run.
  task automatic run_prog(input int len, input int poke_edge, input bit poke_we,
                          output int lat);
    lat = -1;
    @(negedge clk);
    prog_len = (AW+1)'(len);
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("flags_cleared_on_start", 32'({done, error}), 32'd0);
    check("s_rst_in_clear", 32'(s_rst), 32'd1);
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || error) begin
        lat = n;
        break;
      end
      if (n == poke_edge) begin
        if (poke_we) begin
          prog_we   = 1'b1;
          prog_addr = '0;
          prog_op   = OP_PUSH;
          prog_data = 16'hBEEF;
        end else begin
          start    = 1'b1;
          prog_len = 5'd1;
        end
      end else begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
    end
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  task automatic check_run(input string tag, input exp_t e, input int lat);
    check({tag, ".latency"}, 32'(lat), 32'(e.lat));
    check({tag, ".done"}, 32'(done), 32'(!e.err));
    check({tag, ".error"}, 32'(error), 32'(e.err));
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    if (e.err) begin
      check({tag, ".err_pc"}, 32'(err_pc), 32'(e.pc));
    end else begin
      check({tag, ".result"}, 32'(result), 32'(e.res));
      check({tag, ".result_empty"}, 32'(result_empty), 32'(e.empty));
    end
  endtask

  task automatic run_and_check(input string tag, input int len, input int poke_edge,
                               input bit poke_we);
    exp_t e;
    int   lat;
    e = ref_run(len);
    run_prog(len, poke_edge, poke_we, lat);
    check_run(tag, e, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    int   lat;
    logic [3:0] rop;

    vecs[0] = '{ops: {OP_PUSH, OP_PUSH, OP_ADD, OP_POP}, data: {16'd3, 16'd4, 16'd0, 16'd0},
                len: 3, e: '{err: 0, pc: 0, res: 16'd7, empty: 0, lat: 8}};
    vecs[1] = '{ops: {OP_PUSH, OP_PUSH, OP_ADD, OP_POP}, data: {16'd3, 16'd4, 16'd0, 16'd0},
                len: 0, e: '{err: 0, pc: 0, res: 16'd0, empty: 1, lat: 2}};
    vecs[2] = '{ops: {OP_PUSH, OP_PUSH, OP_DIV, OP_POP}, data: {16'd5, 16'd0, 16'd0, 16'd0},
                len: 3, e: '{err: 1, pc: 2, res: 16'd0, empty: 0, lat: 7}};
    vecs[3] = '{ops: {OP_PUSH, 4'd12, OP_ADD, OP_POP}, data: {16'd1, 16'd0, 16'd0, 16'd0},
                len: 2, e: '{err: 1, pc: 1, res: 16'd0, empty: 0, lat: 5}};
    vecs[4] = '{ops: {OP_POP, OP_PUSH, OP_PUSH, OP_ADD}, data: {16'd0, 16'd1, 16'd2, 16'd0},
                len: 1, e: '{err: 1, pc: 0, res: 16'd0, empty: 0, lat: 3}};
    vecs[5] = '{ops: {OP_PUSH, OP_PUSH, OP_SUB, OP_DUP}, data: {16'd10, 16'd3, 16'd0, 16'd0},
                len: 4, e: '{err: 0, pc: 0, res: 16'd7, empty: 0, lat: 10}};
    vecs[6] = '{ops: {OP_PUSH, OP_PUSH, OP_MOD, OP_POP}, data: {16'd17, 16'd5, 16'd0, 16'd0},
                len: 3, e: '{err: 0, pc: 0, res: 16'd2, empty: 0, lat: 8}};
    vecs[7] = '{ops: {OP_PUSH, OP_PUSH, OP_SWAP, OP_POP}, data: {16'd9, 16'd2, 16'd0, 16'd0},
                len: 4, e: '{err: 0, pc: 0, res: 16'd2, empty: 0, lat: 10}};

    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_op   = '0;
    prog_data = '0;
    prog_len  = '0;
    start     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done_error", 32'({done, error}), 32'd0);
    check("reset.result", 32'(result), 32'd0);
    check("reset.result_empty", 32'(result_empty), 32'd1);
    check("reset.s_rst", 32'(s_rst), 32'd1);
    check("reset.s_apply", 32'(s_apply), 32'd0);
    rst = 1'b0;

    // Table-driven programs with hand-derived outcomes.
    for (int v = 0; v < 8; v++) begin
      for (int j = 0; j < 4; j++) write_word(j, vecs[v].ops[j], vecs[v].data[j]);
      run_prog(vecs[v].len, -1, 1'b0, lat);
      check_run($sformatf("vec%0d", v), vecs[v].e, lat);
    end

    // Busy-time start and program writes are ignored.
    for (int j = 0; j < 4; j++) write_word(j, vecs[0].ops[j], vecs[0].data[j]);
    run_and_check("start_while_busy", 3, 3, 1'b0);
    run_and_check("we_while_busy", 3, 3, 1'b1);
    run_and_check("rerun_after_we", 3, -1, 1'b0);

    // Asynchronous reset during the third ISSUE.
    @(negedge clk);
    prog_len = 5'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("midrun.issue3_apply", 32'(s_apply), 32'd1);
    check("midrun.issue3_op", 32'(s_op), 32'(OP_ADD));
    rst = 1'b1;
    #1;
    check("midrun.busy", 32'(busy), 32'd0);
    check("midrun.done_error", 32'({done, error}), 32'd0);
    check("midrun.result", 32'(result), 32'd0);
    check("midrun.result_empty", 32'(result_empty), 32'd1);
    check("midrun.err_pc", 32'(err_pc), 32'd0);
    check("midrun.s_rst", 32'(s_rst), 32'd1);
    check("midrun.s_drive", 32'({s_apply, s_op, s_in}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_and_check("after_reset", 3, -1, 1'b0);

    // Random programs against the reference run.
    for (int it = 0; it < 40; it++) begin
      int len;
      for (int j = 0; j < DEPTH; j++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 45)      rop = OP_PUSH;
        else if (r < 95) rop = 4'($urandom_range(0, 8));
        else             rop = 4'($urandom_range(9, 15));
        write_word(j, rop, 16'($urandom_range(0, 40)));
      end
      len = (it == 0) ? 31 : $urandom_range(0, 20);
      run_and_check($sformatf("rand%0d_len%0d", it, len), len, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
